// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the RV32I hazard controller: forwarding selects,
// the load result-source code and the memory-wait FSM state codes.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;

  localparam logic [1:0] RES_LOAD = 2'b01;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WAIT  = 1'b1;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// EX operand forwarding select for one source register; pure combinational.
// Memory-stage result wins over writeback; x0 is never forwarded.
module fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output logic [1:0] fwd_sel
);

  always_comb begin
    fwd_sel = FWD_RF;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
      fwd_sel = FWD_M;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
      fwd_sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline stall/flush/forward sequencer; all controls combinational, zero added latency.
// Define HAZARD_PERF_EN to add stallCycles/flushCount performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic [1:0]  resultSrcE,
  input  logic        regWriteM,
  input  logic        regWriteW,
  input  logic        PCSrcE,
  input  logic        memReqM,
  input  logic        memReadyM,
  output logic [1:0]  forwardAE,
  output logic [1:0]  forwardBE,
  output logic        stallF,
  output logic        stallD,
  output logic        stallE,
  output logic        stallM,
  output logic        flushD,
  output logic        flushE,
  output logic        flushW,
`ifdef HAZARD_PERF_EN
  output logic [31:0] stallCycles,
  output logic [31:0] flushCount,
`endif
  output logic        memTimeout
);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [1:0]       fwd_a, fwd_b;
  logic             abort, mem_wait, lw_stall;

  fwd_unit u_fwd_a (
    .rs_e        (Rs1E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (regWriteM),
    .reg_write_w (regWriteW),
    .fwd_sel     (fwd_a)
  );

  fwd_unit u_fwd_b (
    .rs_e        (Rs2E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (regWriteM),
    .reg_write_w (regWriteW),
    .fwd_sel     (fwd_b)
  );

  always_comb begin
    abort    = (state_q == ST_WAIT) && (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1));
    mem_wait = memReqM && !memReadyM && !abort;
    lw_stall = (resultSrcE == RES_LOAD) && (RdE != 5'd0) &&
               ((RdE == Rs1D) || (RdE == Rs2D));
  end

  // A memory wait freezes the whole pipe, including a resolved branch in E,
  // which then takes effect once the wait releases.
  always_comb begin
    forwardAE  = '0;
    forwardBE  = '0;
    stallF     = 1'b0;
    stallD     = 1'b0;
    stallE     = 1'b0;
    stallM     = 1'b0;
    flushD     = 1'b0;
    flushE     = 1'b0;
    flushW     = 1'b0;
    memTimeout = 1'b0;
    if (!rst) begin
      forwardAE  = fwd_a;
      forwardBE  = fwd_b;
      stallF     = mem_wait || lw_stall;
      stallD     = mem_wait || lw_stall;
      stallE     = mem_wait;
      stallM     = mem_wait;
      flushW     = mem_wait;
      flushD     = !mem_wait && PCSrcE;
      flushE     = !mem_wait && (lw_stall || PCSrcE);
      memTimeout = mem_timeout_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mem_wait) state_d = ST_WAIT;
      ST_WAIT: if (memReadyM || abort) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    wait_cnt_d    = ((state_q == ST_WAIT) && (state_d == ST_WAIT)) ?
                    wait_cnt_q + CNT_W'(1) : '0;
    mem_timeout_d = mem_timeout_q || abort;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, stallF};
    flush_count_d  = flush_count_q + {31'd0, flushE};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stallCycles = stall_cycles_q;
  assign flushCount  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: combinational vector table plus memory-wait,
// timeout and reset-in-wait sequences.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] resultSrcE;
  logic       regWriteM, regWriteW, PCSrcE, memReqM, memReadyM;
  logic [1:0] forwardAE, forwardBE;
  logic       stallF, stallD, stallE, stallM, flushD, flushE, flushW, memTimeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] stallCycles, flushCount;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [10:0] OUT_IDLE  = 11'b00_00_0000_000;
  localparam logic [10:0] OUT_STALL = 11'b00_00_1111_001;

  // {fwdA, fwdB, stallF, stallD, stallE, stallM, flushD, flushE, flushW}
  logic [10:0] outs;
  assign outs = {forwardAE, forwardBE, stallF, stallD, stallE, stallM, flushD, flushE, flushW};

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .RdM        (RdM),
    .RdW        (RdW),
    .resultSrcE (resultSrcE),
    .regWriteM  (regWriteM),
    .regWriteW  (regWriteW),
    .PCSrcE     (PCSrcE),
    .memReqM    (memReqM),
    .memReadyM  (memReadyM),
    .forwardAE  (forwardAE),
    .forwardBE  (forwardBE),
    .stallF     (stallF),
    .stallD     (stallD),
    .stallE     (stallE),
    .stallM     (stallM),
    .flushD     (flushD),
    .flushE     (flushE),
    .flushW     (flushW),
`ifdef HAZARD_PERF_EN
    .stallCycles(stallCycles),
    .flushCount (flushCount),
`endif
    .memTimeout (memTimeout)
  );

  typedef struct {
    logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0]  res_src;
    logic        rwm, rww, pcsrc, mreq, mrdy;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0; resultSrcE = '0;
    regWriteM = 1'b0; regWriteW = 1'b0; PCSrcE = 1'b0;
    memReqM = 1'b0; memReadyM = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            rs1d  rs2d  rs1e  rs2e  rde   rdm   rdw   res    wM    wW    pc    req   rdy   expected
    vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'b10_00_0000_000};
    vecs[1]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'b00_00_0000_000};
    vecs[2]  = '{5'd0, 5'd0, 5'd3, 5'd3, 5'd0, 5'd4, 5'd3, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'b01_01_0000_000};
    vecs[3]  = '{5'd0, 5'd0, 5'd0, 5'd6, 5'd0, 5'd6, 5'd6, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'b00_00_0000_000};
    vecs[4]  = '{5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 5'd9, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'b00_10_0000_000};
    vecs[5]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'b00_00_1100_010};
    vecs[6]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'b00_00_1100_010};
    vecs[7]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'b00_00_0000_000};
    vecs[8]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'b00_00_0000_000};
    vecs[9]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'b00_00_0000_110};
    vecs[10] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'b00_00_1100_110};
    vecs[11] = '{5'd7, 5'd0, 5'd5, 5'd0, 5'd7, 5'd5, 5'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'b10_00_1100_010};
    vecs[12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11'b00_00_0000_000};

    // Reset with hazards present on the inputs: every output must be held low.
    clear_inputs();
    rst = 1'b1;
    PCSrcE = 1'b1; Rs1E = 5'd5; RdM = 5'd5; regWriteM = 1'b1;
    resultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7; memReqM = 1'b1;
    @(negedge clk);
    check("reset_outs", {21'd0, outs}, {21'd0, OUT_IDLE});
    check("reset_timeout", {31'd0, memTimeout}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    clear_inputs();

    for (int i = 0; i < 13; i++) begin
      Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
      RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw; resultSrcE = vecs[i].res_src;
      regWriteM = vecs[i].rwm; regWriteW = vecs[i].rww; PCSrcE = vecs[i].pcsrc;
      memReqM = vecs[i].mreq; memReadyM = vecs[i].mrdy;
      @(negedge clk);
      check($sformatf("vec%0d", i), {21'd0, outs}, {21'd0, vecs[i].exp});
      tick();
    end
    clear_inputs();
    @(negedge clk);
    check("after_same_cycle_ready", {21'd0, outs}, {21'd0, OUT_IDLE});
    tick();

    // Three-cycle memory wait with a taken branch frozen in E.
    memReqM = 1'b1; memReadyM = 1'b0; PCSrcE = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("wait3_cyc%0d", c), {21'd0, outs}, {21'd0, OUT_STALL});
      tick();
    end
    memReadyM = 1'b1;
    @(negedge clk);
    check("wait3_ready", {21'd0, outs}, {21'd0, 11'b00_00_0000_110});
    tick();
    clear_inputs();
    @(negedge clk);
    check("wait3_after", {21'd0, outs}, {21'd0, OUT_IDLE});
    check("wait3_no_timeout", {31'd0, memTimeout}, 32'd0);
    tick();

    // Reset asserted in the second WAIT cycle.
    memReqM = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_wait_outs", {21'd0, outs}, {21'd0, OUT_IDLE});
    tick();
    rst = 1'b0;
    memReqM = 1'b0;
    @(negedge clk);
    check("post_rst_outs", {21'd0, outs}, {21'd0, OUT_IDLE});
`ifdef HAZARD_PERF_EN
    check("post_rst_stall_cnt", stallCycles, 32'd0);
    check("post_rst_flush_cnt", flushCount, 32'd0);
`endif
    tick();

    // Memory that never answers: exactly 16 stall cycles, then abort and release.
    memReqM = 1'b1; memReadyM = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check($sformatf("tmo_stall%0d", c), {21'd0, outs}, {21'd0, OUT_STALL});
      tick();
    end
    @(negedge clk);
    check("tmo_abort_outs", {21'd0, outs}, {21'd0, OUT_IDLE});
    check("tmo_abort_flag_pending", {31'd0, memTimeout}, 32'd0);
    tick();
    memReqM = 1'b0;
    @(negedge clk);
    check("tmo_flag_set", {31'd0, memTimeout}, 32'd1);
    check("tmo_after_outs", {21'd0, outs}, {21'd0, OUT_IDLE});
    tick();
    tick();
    tick();
    @(negedge clk);
    check("tmo_flag_sticky", {31'd0, memTimeout}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("tmo_flag_cleared", {31'd0, memTimeout}, 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
